// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD-card (SPI mode) command sequencer feeding an SPI byte engine.
// Frames one command (gap filler, 6-byte command frame with CRC7), polls for R1,
// and optionally collects four trailing response bytes (R3/R7).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   spi_ce                clock enable shared with the byte engine
//   cmd_start             start request (sampled in IDLE only)
//   cmd_index, cmd_arg    command number and 32-bit argument
//   resp_ext              read 4 extra bytes after R1
//   busy, done, timeout   command status; done is a one-clk pulse
//   r1, r_ext             R1 byte and extended response (first byte in [31:24])
//   spi_di, spi_wr        byte and write strobe to the byte engine
//   spi_do, spi_dsr       received byte and data-ready from the byte engine
module sd_cmd_seq #(
  parameter int unsigned NCR_MAX   = 8,
  parameter int unsigned GAP_BYTES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_ce,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_ext,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] r_ext,
  output logic [7:0]  spi_di,
  output logic        spi_wr,
  input  logic [7:0]  spi_do,
  input  logic        spi_dsr
);

  typedef enum logic [2:0] {IDLE, GAP, CMD, POLL, EXT, FIN} state_t;
  typedef enum logic [1:0] {XP_NONE, XP_ISSUE, XP_LOW, XP_HIGH} xphase_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_BYTES - 1);
  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

  state_t      state;
  xphase_t     xphase;
  logic [7:0]  cnt;
  logic [39:0] frame;
  logic [6:0]  crc;
  logic        ext_req;
  logic        rx_valid;

  // CRC7 (x^7 + x^3 + 1) advanced by one byte, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[6] ^ d[7 - i];
      r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return r;
  endfunction

  // The strobe is gated combinationally by spi_ce so it lands exactly on an
  // enabled clk; spi_di is registered and held for the whole ISSUE phase.
  assign spi_wr   = (xphase == XP_ISSUE) && spi_ce;
  assign rx_valid = (xphase == XP_HIGH) && spi_dsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      xphase  <= XP_NONE;
      cnt     <= '0;
      frame   <= '0;
      crc     <= '0;
      ext_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      r1      <= '1;
      r_ext   <= '0;
      spi_di  <= '1;
    end else begin
      done <= 1'b0;

      // Transfer handshake: strobe, then dsr must be seen low, then high.
      case (xphase)
        XP_ISSUE: if (spi_ce) xphase <= XP_LOW;
        XP_LOW:   if (!spi_dsr) xphase <= XP_HIGH;
        default:  ;
      endcase

      case (state)
        IDLE: begin
          if (cmd_start) begin
            busy    <= 1'b1;
            timeout <= 1'b0;
            r1      <= '1;
            r_ext   <= '0;
            ext_req <= resp_ext;
            cnt     <= '0;
            xphase  <= XP_ISSUE;
            if (GAP_BYTES == 0) begin
              // Skip the gap: load frame byte 0 straight from the inputs.
              state  <= CMD;
              spi_di <= {2'b01, cmd_index};
              crc    <= crc7_byte('0, {2'b01, cmd_index});
              frame  <= {cmd_arg, 8'h00};
            end else begin
              state  <= GAP;
              spi_di <= '1;
              crc    <= '0;
              frame  <= {2'b01, cmd_index, cmd_arg};
            end
          end
        end

        GAP: begin
          if (rx_valid) begin
            xphase <= XP_ISSUE;
            if (cnt == GAP_LAST) begin
              state  <= CMD;
              cnt    <= '0;
              spi_di <= frame[39:32];
              crc    <= crc7_byte(crc, frame[39:32]);
              frame  <= {frame[31:0], 8'h00};
            end else begin
              cnt    <= cnt + 8'd1;
              spi_di <= '1;
            end
          end
        end

        // Frame bytes are shifted out of 'frame' and folded into the CRC as
        // they are loaded, so the CRC byte is ready when byte 4 completes.
        CMD: begin
          if (rx_valid) begin
            xphase <= XP_ISSUE;
            if (cnt == 8'd5) begin
              state  <= POLL;
              cnt    <= '0;
              spi_di <= '1;
            end else if (cnt == 8'd4) begin
              cnt    <= cnt + 8'd1;
              spi_di <= {crc, 1'b1};
            end else begin
              cnt    <= cnt + 8'd1;
              spi_di <= frame[39:32];
              crc    <= crc7_byte(crc, frame[39:32]);
              frame  <= {frame[31:0], 8'h00};
            end
          end
        end

        POLL: begin
          if (rx_valid) begin
            if (!spi_do[7]) begin
              r1  <= spi_do;
              cnt <= '0;
              if (ext_req) begin
                state  <= EXT;
                spi_di <= '1;
                xphase <= XP_ISSUE;
              end else begin
                state  <= FIN;
                xphase <= XP_NONE;
              end
            end else if (cnt == NCR_LAST) begin
              timeout <= 1'b1;
              r1      <= '1;
              cnt     <= '0;
              state   <= FIN;
              xphase  <= XP_NONE;
            end else begin
              cnt    <= cnt + 8'd1;
              spi_di <= '1;
              xphase <= XP_ISSUE;
            end
          end
        end

        EXT: begin
          if (rx_valid) begin
            r_ext <= {r_ext[23:0], spi_do};
            if (cnt == 8'd3) begin
              cnt    <= '0;
              state  <= FIN;
              xphase <= XP_NONE;
            end else begin
              cnt    <= cnt + 8'd1;
              spi_di <= '1;
              xphase <= XP_ISSUE;
            end
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          xphase <= XP_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Testbench for sd_cmd_seq: byte-engine and card model plus a transaction-level
// reference that predicts wire bytes, R1, timeout, r_ext and done/busy timing.
module tb_sd_cmd_seq;

  localparam int NCR = 8;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        reset_n, spi_ce, cmd_start, resp_ext, spi_dsr, spi_wr;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg, r_ext;
  logic [7:0]  spi_do, spi_di, r1;
  logic        busy, done, timeout;

  sd_cmd_seq #(.NCR_MAX(NCR), .GAP_BYTES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .spi_ce(spi_ce), .cmd_start(cmd_start),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_ext(resp_ext),
    .busy(busy), .done(done), .timeout(timeout), .r1(r1), .r_ext(r_ext),
    .spi_di(spi_di), .spi_wr(spi_wr), .spi_do(spi_do), .spi_dsr(spi_dsr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  card_q[$];   // byte the card returns on each transfer of a command
  logic [7:0]  exp_wire[$]; // predicted bytes on the wire
  logic [7:0]  wire_q[$];   // bytes actually strobed by the DUT
  logic [7:0]  exp_r1;
  logic        exp_to;
  logic [31:0] exp_rext;
  bit exp_busy, exp_done, accept_pending, start_req, done_seen;
  bit eng_busy, wr_prev, ce_prev;
  int eng_cnt, fin_age, ce_mode, cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC7 as polynomial long division of msg*x^7 by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [7:0] card_byte(input int k);
    return (k < card_q.size()) ? card_q[k] : 8'hFF;
  endfunction

  task automatic build_model(input logic [5:0] idx, input logic [31:0] arg, input bit ext);
    logic [39:0] msg;
    logic [7:0]  b;
    bit          hit;
    exp_wire.delete();
    for (int i = 0; i < GAP; i++) exp_wire.push_back(8'hFF);
    msg = {2'b01, idx, arg};
    for (int i = 0; i < 5; i++) exp_wire.push_back(msg[39 - 8*i -: 8]);
    exp_wire.push_back({ref_crc7(msg), 1'b1});
    exp_r1 = 8'hFF; exp_to = 1'b1; exp_rext = '0; hit = 1'b0;
    for (int p = 0; p < NCR && !hit; p++) begin
      b = card_byte(exp_wire.size());
      exp_wire.push_back(8'hFF);
      if (!b[7]) begin hit = 1'b1; exp_r1 = b; exp_to = 1'b0; end
    end
    if (hit && ext)
      for (int i = 0; i < 4; i++) begin
        exp_rext = {exp_rext[23:0], card_byte(exp_wire.size())};
        exp_wire.push_back(8'hFF);
      end
  endtask

  // One clock: engine/card react at the falling edge, inputs are driven,
  // then outputs are sampled and compared 1 ns later.
  task automatic step();
    bit just_accepted;
    @(negedge clk);
    cyc++;
    if (fin_age >= 0) fin_age++;
    just_accepted = accept_pending;
    accept_pending = 1'b0;
    if (just_accepted) exp_busy = 1'b1;
    if (wr_prev) begin
      spi_dsr = 1'b0; eng_busy = 1'b1; eng_cnt = $urandom_range(1, 3);
    end else if (eng_busy && ce_prev) begin
      if (eng_cnt <= 1) begin
        spi_dsr = 1'b1; spi_do = card_byte(wire_q.size() - 1); eng_busy = 1'b0;
        if (exp_busy && wire_q.size() == exp_wire.size()) fin_age = 0;
      end else eng_cnt--;
    end
    cmd_start = start_req;
    if (start_req && !exp_busy) accept_pending = 1'b1;
    start_req = 1'b0;
    case (ce_mode)
      0:       spi_ce = 1'b1;
      1:       spi_ce = (cyc % 4 == 0);
      default: spi_ce = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (spi_wr) begin
      check("wr_needs_ce", 32'(spi_ce), 32'd1);
      check("wr_outstanding", 32'({eng_busy, spi_dsr}), 32'd1);
      if (wire_q.size() < exp_wire.size())
        check("wire_byte", 32'(spi_di), 32'(exp_wire[wire_q.size()]));
      else
        check("wr_count", 32'(wire_q.size() + 1), 32'(exp_wire.size()));
      wire_q.push_back(spi_di);
    end
    if (just_accepted) begin
      check("start_r1", 32'(r1), 32'hFF);
      check("start_timeout", 32'(timeout), 32'd0);
      check("start_r_ext", r_ext, 32'd0);
    end
    exp_done = (fin_age == 2);
    if (exp_done) exp_busy = 1'b0;
    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy));
    if (exp_done) begin
      check("r1", 32'(r1), 32'(exp_r1));
      check("timeout", 32'(timeout), 32'(exp_to));
      check("r_ext", r_ext, exp_rext);
      check("xfer_count", 32'(wire_q.size()), 32'(exp_wire.size()));
      done_seen = 1'b1;
      fin_age = -1;
    end
    wr_prev = spi_wr;
    ce_prev = spi_ce;
  endtask

  task automatic model_reset();
    eng_busy = 1'b0; spi_dsr = 1'b1; spi_do = 8'hFF; exp_busy = 1'b0;
    fin_age = -1; wr_prev = 1'b0; ce_prev = 1'b0; accept_pending = 1'b0; start_req = 1'b0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit ext,
                         input int abort_at, input bit stray);
    bit stray_sent;
    int n;
    stray_sent = 1'b0;
    wire_q.delete();
    build_model(idx, arg, ext);
    cmd_index = idx; cmd_arg = arg; resp_ext = ext;
    start_req = 1'b1;
    done_seen = 1'b0;
    for (n = 0; n < 3000 && !done_seen; n++) begin
      step();
      if (stray && !stray_sent && wire_q.size() == 3) begin
        stray_sent = 1'b1; start_req = 1'b1;
        cmd_index = 6'h3F; cmd_arg = $urandom; resp_ext = 1'b1;
      end
      if (abort_at >= 0 && wire_q.size() == abort_at + 1) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_r1", 32'(r1), 32'hFF);
        check("rst_r_ext", r_ext, 32'd0);
        check("rst_spi_di", 32'(spi_di), 32'hFF);
        check("rst_spi_wr", 32'(spi_wr), 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          check("rst_hold_done", 32'({done, busy, spi_wr}), 32'd0);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        return;
      end
    end
    if (!done_seen) begin
      vectors++; errors++;
      $display("FAIL done_wait: no done within %0d cycles, %0d bytes sent", n, wire_q.size());
    end
    repeat (3) step();
  endtask

  task automatic card_r1(input int poll_pos, input logic [7:0] r, input logic [31:0] ext);
    card_q.delete();
    for (int i = 0; i < GAP + 6 + poll_pos; i++) card_q.push_back(8'hFF);
    card_q.push_back(r);
    for (int i = 0; i < 4; i++) card_q.push_back(ext[31 - 8*i -: 8]);
  endtask

  initial begin
    int hitp;
    reset_n = 1'b0; spi_ce = 1'b0; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0;
    resp_ext = 1'b0; cyc = 0; ce_mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_r1", 32'(r1), 32'hFF);
    check("reset_spi_di", 32'(spi_di), 32'hFF);
    check("reset_spi_wr", 32'(spi_wr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // CMD0, R1 0x01 on second poll
    card_r1(1, 8'h01, 32'hFFFFFFFF);
    run_cmd(6'd0, 32'h0, 1'b0, -1, 1'b0);
    check("t1_cmd_byte", 32'(wire_q[GAP]), 32'h40);
    check("t1_crc_byte", 32'(wire_q[GAP + 5]), 32'h95);
    check("t1_len", 32'(wire_q.size()), 32'd9);
    check("t1_r1", 32'(r1), 32'h01);

    // CMD8 with R7 tail
    card_r1(0, 8'h01, 32'h000001AA);
    run_cmd(6'd8, 32'h000001AA, 1'b1, -1, 1'b0);
    check("t2_cmd_byte", 32'(wire_q[GAP]), 32'h48);
    check("t2_crc_byte", 32'(wire_q[GAP + 5]), 32'h87);
    check("t2_r_ext", r_ext, 32'h000001AA);

    // silent card: NCR poll bytes then timeout
    card_q.delete();
    run_cmd(6'd0, 32'h0, 1'b0, -1, 1'b0);
    check("t3_len", 32'(wire_q.size()), 32'(GAP + 6 + 8));
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_r1", 32'(r1), 32'hFF);

    // sparse enable, stray start during busy
    ce_mode = 1;
    card_r1(1, 8'h01, 32'hFFFFFFFF);
    run_cmd(6'd0, 32'h0, 1'b0, -1, 1'b1);
    check("t4_crc_byte", 32'(wire_q[GAP + 5]), 32'h95);

    // reset during frame byte 3, then a clean CMD0
    ce_mode = 0;
    run_cmd(6'd0, 32'h0, 1'b0, GAP + 3, 1'b0);
    card_r1(1, 8'h01, 32'hFFFFFFFF);
    run_cmd(6'd0, 32'h0, 1'b0, -1, 1'b0);
    check("t5_r1", 32'(r1), 32'h01);

    // CMD17, R1 0x00 on first poll
    card_r1(0, 8'h00, 32'hFFFFFFFF);
    run_cmd(6'd17, 32'h00000200, 1'b0, -1, 1'b0);
    check("t6_r1", 32'(r1), 32'h00);
    check("t6_len", 32'(wire_q.size()), 32'(GAP + 7));

    // randomized commands and card behaviour
    for (int t = 0; t < 30; t++) begin
      ce_mode = $urandom_range(0, 2);
      card_q.delete();
      for (int i = 0; i < GAP + 6; i++) card_q.push_back(8'($urandom));
      hitp = $urandom_range(0, NCR);
      for (int p = 0; p < NCR; p++)
        card_q.push_back((p == hitp) ? {1'b0, 7'($urandom)} : {1'b1, 7'($urandom)});
      for (int i = 0; i < 4; i++) card_q.push_back(8'($urandom));
      run_cmd(6'($urandom), $urandom, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
